bird_motion_ctrl: RTL and testbench

//  Game-flow FSM and motion scheduler for the bird sprite. Generates the slow

---
 rtl/bird_motion_ctrl.sv | 142 ++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bird_motion_ctrl.sv
// Game-flow FSM and motion scheduler for the bird sprite: movement tick,
// flap edge detection, vertical position and IDLE/PLAY/DYING/OVER sequencing.
module bird_motion_ctrl #(
  parameter int TICK_DIV  = 524287,
  parameter int Y_START   = 320,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 448,
  parameter int FLAP_STEP = 4,
  parameter int FALL_STEP = 2
) (
  input  logic       clk,
  input  logic       resetGame_n,
  input  logic       press,
  input  logic       collide,
  input  logic       pass,
  output logic [8:0] bird_y,
  output logic       move_tick,
  output logic [1:0] state,
  output logic       playing,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int CW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [CW-1:0] CNT_TC  = CW'(TICK_DIV);
  localparam logic [9:0]    Y_MIN_E = 10'(Y_MIN);
  localparam logic [9:0]    Y_MAX_E = 10'(Y_MAX);
  localparam logic [9:0]    FLAP_E  = 10'(FLAP_STEP);
  localparam logic [9:0]    FALL_E  = 10'(FALL_STEP);
  localparam logic [8:0]    Y_START_E = 9'(Y_START);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DYING = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          press_q_r;
  logic          flap_pend_r;
  logic          rise_s;
  logic          tick_s;
  logic [9:0]    y_ext_s;
  logic [9:0]    y_up_s;
  logic [9:0]    y_dn_s;

  assign state   = state_r;
  assign rise_s  = press & ~press_q_r;
  assign tick_s  = (cnt_r == CNT_TC);
  // Position arithmetic is one bit wider than bird_y so clamping never sees a wrap.
  assign y_ext_s = {1'b0, bird_y};
  assign y_up_s  = (y_ext_s >= (Y_MIN_E + FLAP_E)) ? (y_ext_s - FLAP_E) : Y_MIN_E;
  assign y_dn_s  = ((y_ext_s + FALL_E) >= Y_MAX_E) ? Y_MAX_E : (y_ext_s + FALL_E);

  // Game-flow state machine with its registered outputs, tick counter and flap latch.
  always_ff @(posedge clk or negedge resetGame_n) begin
    if (!resetGame_n) begin
      state_r     <= ST_IDLE;
      bird_y      <= Y_START_E;
      score       <= 8'd0;
      cnt_r       <= '0;
      flap_pend_r <= 1'b0;
      press_q_r   <= 1'b0;
      move_tick   <= 1'b0;
      playing     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      press_q_r <= press;
      move_tick <= tick_s && ((state_r == ST_PLAY) || (state_r == ST_DYING));
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (rise_s) begin
            state_r     <= ST_PLAY;
            playing     <= 1'b1;
            game_over   <= 1'b0;
            score       <= 8'd0;
            bird_y      <= Y_START_E;
            flap_pend_r <= 1'b0;
          end
        end
        ST_PLAY: begin
          cnt_r <= tick_s ? '0 : (cnt_r + CW'(1));
          if (collide) begin
            state_r     <= ST_DYING;
            playing     <= 1'b0;
            flap_pend_r <= 1'b0;
          end else begin
            if (pass && (score != 8'hFF)) begin
              score <= score + 8'd1;
            end
            if (tick_s) begin
              // A rise on the tick edge is kept for the following tick.
              flap_pend_r <= rise_s;
              if (flap_pend_r) begin
                bird_y <= y_up_s[8:0];
              end else begin
                bird_y <= y_dn_s[8:0];
                if (y_dn_s == Y_MAX_E) begin
                  state_r     <= ST_OVER;
                  playing     <= 1'b0;
                  game_over   <= 1'b1;
                  flap_pend_r <= 1'b0;
                end
              end
            end else begin
              flap_pend_r <= flap_pend_r | rise_s;
            end
          end
        end
        ST_DYING: begin
          cnt_r <= tick_s ? '0 : (cnt_r + CW'(1));
          if (tick_s) begin
            bird_y <= y_dn_s[8:0];
            if (y_dn_s == Y_MAX_E) begin
              state_r   <= ST_OVER;
              game_over <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          cnt_r <= '0;
          if (rise_s) begin
            state_r   <= ST_IDLE;
            game_over <= 1'b0;
            bird_y    <= Y_START_E;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          playing     <= 1'b0;
          game_over   <= 1'b0;
          cnt_r       <= '0;
          flap_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl (TICK_DIV=3): expected snapshots are
// queued as stimulus is applied and compared when the outputs are sampled.
module tb_bird_motion_ctrl;

  logic       clk = 1'b0;
  logic       resetGame_n = 1'b0;
  logic       press = 1'b0;
  logic       collide = 1'b0;
  logic       pass = 1'b0;
  logic [8:0] bird_y;
  logic       move_tick;
  logic [1:0] state;
  logic       playing;
  logic       game_over;
  logic [7:0] score;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    int    y;
    int    st;
    int    sc;
  } exp_t;
  exp_t sb_q[$];

  bird_motion_ctrl #(.TICK_DIV(3)) dut (
    .clk(clk), .resetGame_n(resetGame_n), .press(press), .collide(collide),
    .pass(pass), .bird_y(bird_y), .move_tick(move_tick), .state(state),
    .playing(playing), .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int y, input int st, input int sc);
    exp_t e;
    e.tag = tag; e.y = y; e.st = st; e.sc = sc;
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got=0 expected=1");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      cmp({e.tag, "_y"}, 32'(bird_y), 32'(e.y));
      cmp({e.tag, "_state"}, 32'(state), 32'(e.st));
      cmp({e.tag, "_score"}, 32'(score), 32'(e.sc));
      cmp({e.tag, "_playing"}, 32'(playing), (e.st == 1) ? 32'd1 : 32'd0);
      cmp({e.tag, "_game_over"}, 32'(game_over), (e.st == 3) ? 32'd1 : 32'd0);
    end
  endtask

  // One 4-clock tick period starting just after a tick edge.
  task automatic tick_step(input bit fl, input bit p1, input bit p2);
    pass = p1;  clocks(1); pass = 1'b0;
    press = fl; clocks(1); press = 1'b0;
    pass = p2;  clocks(1); pass = 1'b0;
    clocks(1);
  endtask

  initial begin
    // Reset state
    push("reset", 320, 0, 0);
    clocks(2);
    check();
    cmp("reset_move_tick", 32'(move_tick), 32'd0);
    resetGame_n = 1'b1;

    // Held press gives a single PLAY entry, then free fall
    push("t2_entry", 320, 1, 0);
    press = 1'b1;
    clocks(1);
    check();
    push("t2_fall4", 328, 1, 0);
    clocks(16);
    check();
    cmp("t2_move_tick_hi", 32'(move_tick), 32'd1);
    clocks(1);
    cmp("t2_move_tick_lo", 32'(move_tick), 32'd0);
    push("t2_held", 328, 1, 0);
    clocks(2);
    check();
    press = 1'b0;
    push("t2_fall5", 330, 1, 0);
    clocks(1);
    check();

    // Flap up to the ceiling without wrapping
    for (int i = 0; i < 82; i++) tick_step(1'b1, 1'b0, 1'b0);
    push("t3_y2", 2, 1, 0);
    check();
    push("t3_ceiling", 0, 1, 0);
    tick_step(1'b1, 1'b0, 1'b0);
    check();
    push("t3_no_wrap", 0, 1, 0);
    tick_step(1'b1, 1'b0, 1'b0);
    check();
    // Rise on the tick edge is deferred to the next tick
    push("t3_rise_on_tick", 2, 1, 0);
    clocks(3); press = 1'b1; clocks(1); press = 1'b0;
    check();
    push("t3_deferred_flap", 0, 1, 0);
    clocks(4);
    check();

    // Fall onto the ground ends the game on the same edge
    push("t4_y446", 446, 1, 0);
    clocks(4 * 223);
    check();
    push("t4_land", 448, 3, 0);
    clocks(4);
    check();

    // Restart, climb to y=100 with score 5
    push("t5_to_idle", 320, 0, 0);
    press = 1'b1; clocks(1); press = 1'b0;
    check();
    push("t5_entry", 320, 1, 0);
    clocks(1); press = 1'b1; clocks(1); press = 1'b0;
    check();
    for (int i = 0; i < 55; i++) tick_step(1'b1, (i < 5), 1'b0);
    push("t5_setup", 100, 1, 5);
    check();
    // Collide wins over tick move and pass in the same cycle
    push("t5_collide", 100, 2, 5);
    clocks(3);
    collide = 1'b1; pass = 1'b1; press = 1'b1;
    clocks(1);
    collide = 1'b0; pass = 1'b0; press = 1'b0;
    check();
    push("t5_dying_fall", 446, 2, 5);
    for (int i = 0; i < 173; i++) tick_step(1'b1, 1'b1, 1'b1);
    check();
    push("t5_dying_over", 448, 3, 5);
    tick_step(1'b1, 1'b1, 1'b1);
    check();

    // Score saturation and reset of score on next PLAY entry
    push("t6_idle_keeps_score", 320, 0, 5);
    press = 1'b1; clocks(1); press = 1'b0;
    check();
    push("t6_entry", 320, 1, 0);
    clocks(1); press = 1'b1; clocks(1); press = 1'b0;
    check();
    for (int i = 0; i < 128; i++) tick_step(1'b1, 1'b1, 1'b1);
    push("t6_saturate", 0, 1, 255);
    check();
    push("t6_dying", 2, 2, 255);
    collide = 1'b1; clocks(1); collide = 1'b0; clocks(3);
    check();
    push("t6_over", 448, 3, 255);
    clocks(4 * 223);
    check();
    push("t6_idle", 320, 0, 255);
    press = 1'b1; clocks(1); press = 1'b0;
    check();
    push("t6_play", 320, 1, 0);
    clocks(1); press = 1'b1; clocks(1); press = 1'b0;
    check();

    // Asynchronous reset mid-game
    for (int i = 0; i < 5; i++) tick_step(1'b1, 1'b1, 1'b0);
    push("t1_pre_reset", 300, 1, 5);
    check();
    push("t1_async_reset", 320, 0, 0);
    resetGame_n = 1'b0;
    #1;
    check();
    cmp("t1_move_tick", 32'(move_tick), 32'd0);
    clocks(2);
    resetGame_n = 1'b1;
    clocks(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
